// File: rtl/control_unit.sv
// Multi-cycle control unit: a five-state instruction sequencer that decodes the registered
// state plus the instruction word into the data-path control word and the memory strobes.
//
//   state      | meaning
//   FETCH      | read instruction memory at PC
//   DECODE     | latch IR, read register file
//   EXECUTE    | drive ALU operation and operand selects
//   MEMORY     | hold ALU selects, perform load/store/stack access
//   WRITE_BACK | register write and PC update
module control_unit #(
  parameter int CTRL_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic              READ,
  output logic              WRITE,
  output logic [2:0]        STATE
);

  localparam logic [2:0] FETCH      = 3'd0;
  localparam logic [2:0] DECODE     = 3'd1;
  localparam logic [2:0] EXECUTE    = 3'd2;
  localparam logic [2:0] MEMORY     = 3'd3;
  localparam logic [2:0] WRITE_BACK = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [5:0] ALU_NONE = 6'd0;
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;
  localparam logic [5:0] ALU_MUL  = 6'd3;
  localparam logic [5:0] ALU_SRL  = 6'd4;
  localparam logic [5:0] ALU_SLL  = 6'd5;
  localparam logic [5:0] ALU_AND  = 6'd6;
  localparam logic [5:0] ALU_OR   = 6'd7;
  localparam logic [5:0] ALU_NOR  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;

  localparam int B_PC_LOAD  = 0;
  localparam int B_PC_SEL1  = 1;
  localparam int B_PC_SEL2  = 2;
  localparam int B_PC_SEL3  = 3;
  localparam int B_IR_LOAD  = 4;
  localparam int B_REG_R    = 5;
  localparam int B_REG_W    = 6;
  localparam int B_R1_SEL1  = 7;
  localparam int B_WA_SEL1  = 8;
  localparam int B_WA_SEL2  = 9;
  localparam int B_WA_SEL3  = 10;
  localparam int B_SP_LOAD  = 11;
  localparam int B_OP1_SEL1 = 12;
  localparam int B_OP2_SEL1 = 13;
  localparam int B_OP2_SEL2 = 14;
  localparam int B_OP2_SEL3 = 15;
  localparam int B_OP2_SEL4 = 16;
  localparam int B_WD_SEL1  = 17;
  localparam int B_WD_SEL2  = 18;
  localparam int B_WD_SEL3  = 19;
  localparam int B_MA_SEL1  = 20;
  localparam int B_MA_SEL2  = 21;
  localparam int B_MD_SEL1  = 22;
  localparam int B_ALU_LSB  = 23;

  logic [2:0]  state;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        unused_instr_bits;

  logic [5:0]  alu_op;
  logic        r_alu, r_shift, is_jr;
  logic        i_alu, i_signed;
  logic        is_beq, is_bne, is_lw, is_sw, is_push, is_pop, is_lui, is_jmp, is_jal;
  logic        op1_sel_1, op2_sel_1, op2_sel_2, op2_sel_3, op2_sel_4;
  logic [31:0] ctrl_word;
  logic        read_c, write_c;

  assign opcode            = INSTRUCTION[31:26];
  assign funct             = INSTRUCTION[5:0];
  assign unused_instr_bits = ^INSTRUCTION[25:6];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE:  state <= EXECUTE;
        EXECUTE: state <= MEMORY;
        MEMORY:  state <= WRITE_BACK;
        default: state <= FETCH;
      endcase
    end
  end

  // Instruction classification; unknown opcodes and functs leave every flag clear (NOP).
  always_comb begin
    alu_op   = ALU_NONE;
    r_alu    = 1'b0;
    r_shift  = 1'b0;
    is_jr    = 1'b0;
    i_alu    = 1'b0;
    i_signed = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_push  = 1'b0;
    is_pop   = 1'b0;
    is_lui   = 1'b0;
    is_jmp   = 1'b0;
    is_jal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; r_alu = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; r_alu = 1'b1; end
          FN_MUL: begin alu_op = ALU_MUL; r_alu = 1'b1; end
          FN_AND: begin alu_op = ALU_AND; r_alu = 1'b1; end
          FN_OR:  begin alu_op = ALU_OR;  r_alu = 1'b1; end
          FN_NOR: begin alu_op = ALU_NOR; r_alu = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; r_alu = 1'b1; end
          FN_SLL: begin alu_op = ALU_SLL; r_shift = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; r_shift = 1'b1; end
          FN_JR:  is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; i_alu = 1'b1; i_signed = 1'b1; end
      OP_MULI: begin alu_op = ALU_MUL; i_alu = 1'b1; i_signed = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; i_alu = 1'b1; i_signed = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; i_alu = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  i_alu = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; is_beq = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; is_bne = 1'b1; end
      OP_LW:   begin alu_op = ALU_ADD; is_lw = 1'b1; end
      OP_SW:   begin alu_op = ALU_ADD; is_sw = 1'b1; end
      OP_PUSH: begin alu_op = ALU_SUB; is_push = 1'b1; end
      OP_POP:  begin alu_op = ALU_ADD; is_pop = 1'b1; end
      OP_LUI:  is_lui = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: ;
    endcase
  end

  // Stack ops address through SP and take the constant 1 as the second operand.
  assign op1_sel_1 = is_push | is_pop;
  assign op2_sel_1 = r_shift;
  assign op2_sel_2 = i_signed | is_lw | is_sw;
  assign op2_sel_3 = r_shift | is_push | is_pop;
  assign op2_sel_4 = r_alu | is_beq | is_bne;

  always_comb begin
    ctrl_word = 32'd0;
    read_c    = 1'b0;
    write_c   = 1'b0;
    if (!RST) begin
      case (state)
        FETCH: begin
          read_c               = 1'b1;
          ctrl_word[B_MA_SEL2] = 1'b1;
        end
        DECODE: begin
          ctrl_word[B_IR_LOAD] = 1'b1;
          ctrl_word[B_REG_R]   = 1'b1;
          ctrl_word[B_R1_SEL1] = is_push;
        end
        EXECUTE, MEMORY: begin
          ctrl_word[B_ALU_LSB +: 6] = alu_op;
          ctrl_word[B_OP1_SEL1]     = op1_sel_1;
          ctrl_word[B_OP2_SEL1]     = op2_sel_1;
          ctrl_word[B_OP2_SEL2]     = op2_sel_2;
          ctrl_word[B_OP2_SEL3]     = op2_sel_3;
          ctrl_word[B_OP2_SEL4]     = op2_sel_4;
          if (state == MEMORY) begin
            read_c                = is_lw | is_pop;
            write_c               = is_sw | is_push;
            ctrl_word[B_MD_SEL1]  = is_push;
            ctrl_word[B_MA_SEL1]  = is_push | is_pop;
            ctrl_word[B_SP_LOAD]  = is_push | is_pop;
          end
        end
        WRITE_BACK: begin
          ctrl_word[B_PC_LOAD] = 1'b1;
          ctrl_word[B_PC_SEL1] = ~is_jr;
          ctrl_word[B_PC_SEL2] = (is_beq & ZERO) | (is_bne & ~ZERO);
          ctrl_word[B_PC_SEL3] = ~(is_jmp | is_jal);
          ctrl_word[B_REG_W]   = r_alu | r_shift | i_alu | is_lui | is_lw | is_pop | is_jal;
          ctrl_word[B_WA_SEL1] = i_alu | is_lui | is_lw;
          ctrl_word[B_WA_SEL2] = is_jal;
          ctrl_word[B_WA_SEL3] = r_alu | r_shift | i_alu | is_lui | is_lw;
          ctrl_word[B_WD_SEL1] = is_lw | is_pop;
          ctrl_word[B_WD_SEL2] = is_lui;
          ctrl_word[B_WD_SEL3] = r_alu | r_shift | i_alu | is_lui | is_lw | is_pop;
        end
        default: ;
      endcase
    end
  end

  assign CTRL  = CTRL_W'(ctrl_word);
  assign READ  = read_c;
  assign WRITE = write_c;
  assign STATE = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each instruction pushes its five expected cycles into a
// scoreboard queue, which is drained and compared once per cycle away from the clock edge.
module tb_control_unit;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [31:0] ctrl;
    logic        rd;
    logic        wr;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic        READ;
  logic        WRITE;
  logic [2:0]  STATE;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  control_unit #(.CTRL_W(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .INSTRUCTION(INSTRUCTION),
    .ZERO(ZERO),
    .CTRL(CTRL),
    .READ(READ),
    .WRITE(WRITE),
    .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_exp(input string tag, input logic [2:0] st, input logic [31:0] ctrl,
                          input logic rd, input logic wr);
    exp_t e;
    e.tag = tag; e.st = st; e.ctrl = ctrl; e.rd = rd; e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: observed no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (STATE === e.st) else begin
      bad++; $error("FAIL %s state: got %0d want %0d", e.tag, STATE, e.st);
    end
    total++;
    assert (CTRL === e.ctrl) else begin
      bad++; $error("FAIL %s ctrl: got %h want %h", e.tag, CTRL, e.ctrl);
    end
    total++;
    assert (READ === e.rd) else begin
      bad++; $error("FAIL %s read: got %b want %b", e.tag, READ, e.rd);
    end
    total++;
    assert (WRITE === e.wr) else begin
      bad++; $error("FAIL %s write: got %b want %b", e.tag, WRITE, e.wr);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic z,
                           input logic [31:0] c_d, input logic [31:0] c_e,
                           input logic [31:0] c_m, input logic m_rd, input logic m_wr,
                           input logic [31:0] c_wb);
    INSTRUCTION = instr;
    ZERO        = z;
    push_exp({tag, "_F"},  3'd0, 32'h0020_0000, 1'b1, 1'b0);
    push_exp({tag, "_D"},  3'd1, c_d,  1'b0, 1'b0);
    push_exp({tag, "_E"},  3'd2, c_e,  1'b0, 1'b0);
    push_exp({tag, "_M"},  3'd3, c_m,  m_rd, m_wr);
    push_exp({tag, "_WB"}, 3'd4, c_wb, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_cycle();
      @(negedge CLK);
    end
  endtask

  initial begin
    RST         = 1'b1;
    INSTRUCTION = 32'd0;
    ZERO        = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    push_exp("reset", 3'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check_cycle();
    RST = 1'b0;

    //         tag     instr         Z     DECODE        EXECUTE       MEMORY      rd    wr    WRITE_BACK
    run_instr("add",   32'h0022_1820, 1'b0, 32'h0000_0030, 32'h0081_0000, 32'h0081_0000, 1'b0, 1'b0, 32'h0008_044B);
    run_instr("beq_z1",32'h1022_0003, 1'b1, 32'h0000_0030, 32'h0101_0000, 32'h0101_0000, 1'b0, 1'b0, 32'h0000_000F);
    run_instr("beq_z0",32'h1022_0003, 1'b0, 32'h0000_0030, 32'h0101_0000, 32'h0101_0000, 1'b0, 1'b0, 32'h0000_000B);
    run_instr("bne_z0",32'h1422_0003, 1'b0, 32'h0000_0030, 32'h0101_0000, 32'h0101_0000, 1'b0, 1'b0, 32'h0000_000F);
    run_instr("sw",    32'hAC22_0004, 1'b0, 32'h0000_0030, 32'h0080_4000, 32'h0080_4000, 1'b0, 1'b1, 32'h0000_000B);
    run_instr("jal",   32'h0C00_0010, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0243);
    run_instr("lw",    32'h8C22_0000, 1'b0, 32'h0000_0030, 32'h0080_4000, 32'h0080_4000, 1'b1, 1'b0, 32'h000A_054B);
    run_instr("bad_op",32'hFC00_0000, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_000B);
    run_instr("bad_fn",32'h0000_003F, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_000B);
    run_instr("push",  32'h6C00_0000, 1'b0, 32'h0000_00B0, 32'h0100_9000, 32'h0150_9800, 1'b0, 1'b1, 32'h0000_000B);
    run_instr("pop",   32'h7000_0000, 1'b0, 32'h0000_0030, 32'h0080_9000, 32'h0090_9800, 1'b1, 1'b0, 32'h000A_004B);
    run_instr("sll",   32'h0000_0001, 1'b0, 32'h0000_0030, 32'h0280_A000, 32'h0280_A000, 1'b0, 1'b0, 32'h0008_044B);
    run_instr("addi",  32'h2022_0005, 1'b0, 32'h0000_0030, 32'h0080_4000, 32'h0080_4000, 1'b0, 1'b0, 32'h0008_054B);
    run_instr("andi",  32'h3000_0000, 1'b0, 32'h0000_0030, 32'h0300_0000, 32'h0300_0000, 1'b0, 1'b0, 32'h0008_054B);
    run_instr("lui",   32'h3C01_0005, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h000C_054B);
    run_instr("jr",    32'h0000_0008, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0009);

    // Reset asserted during MEMORY of lw abandons the instruction.
    INSTRUCTION = 32'h8C22_0000;
    push_exp("rlw_F", 3'd0, 32'h0020_0000, 1'b1, 1'b0);
    push_exp("rlw_D", 3'd1, 32'h0000_0030, 1'b0, 1'b0);
    push_exp("rlw_E", 3'd2, 32'h0080_4000, 1'b0, 1'b0);
    push_exp("rlw_M", 3'd3, 32'h0080_4000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_cycle();
      if (i < 3) @(negedge CLK);
    end
    RST = 1'b1;
    push_exp("rlw_hold_M", 3'd3, 32'd0, 1'b0, 1'b0);
    #1;
    check_cycle();
    @(negedge CLK);
    push_exp("rlw_after", 3'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check_cycle();
    RST = 1'b0;
    run_instr("post_rst_add", 32'h0022_1820, 1'b0, 32'h0000_0030, 32'h0081_0000, 32'h0081_0000, 1'b0, 1'b0, 32'h0008_044B);

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
